// File: rtl/rr_request_arbiter.sv
// rr_request_arbiter: four-requester round-robin arbiter with a registered
// one-hot grant. A grant is held until the grantee signals done, drops its
// request, or the optional hold timeout expires. A release always leaves at
// least one all-zero cycle before the next grant, so the downstream 4-to-2
// encoder sees a clean gap between grantees.
module rr_request_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         timeout
);

  localparam int IDX_W = (N < 2) ? 1 : $clog2(N);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   ptr_r, ptr_s;
  logic [IDX_W-1:0]   gidx_r, gidx_s;
  logic [CNT_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic [N-1:0]       grant_r, grant_s;
  logic               grant_valid_r;
  logic               timeout_r, timeout_s;

  logic [IDX_W-1:0]   pick_s;
  logic [IDX_W-1:0]   cand_s;
  logic               found_s;
  logic               tmo_hit_s;
  logic               release_s;

  // Round-robin pick: first asserted request scanning from ptr upward, wrapping.
  always_comb begin
    pick_s  = ptr_r;
    cand_s  = ptr_r;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s = ptr_r + IDX_W'(k);
      if (!found_s && req[cand_s]) begin
        pick_s  = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Hold-timeout condition: the grant has been visible for MAX_HOLD cycles.
  always_comb begin
    tmo_hit_s = 1'b0;
    if (MAX_HOLD != 0) begin
      tmo_hit_s = (hold_cnt_r == CNT_W'(MAX_HOLD - 1));
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Next-state and next-output decision for the IDLE/GRANT controller.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    gidx_s     = gidx_r;
    hold_cnt_s = hold_cnt_r;
    grant_s    = grant_r;
    timeout_s  = 1'b0;
    release_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // done is meaningless here and deliberately not looked at
        if (|req) begin
          grant_s         = '0;
          grant_s[pick_s] = 1'b1;
          gidx_s          = pick_s;
          hold_cnt_s      = '0;
          state_s         = ST_GRANT;
        end else begin
          grant_s = '0;
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        release_s = done || !req[gidx_r] || tmo_hit_s;
        if (release_s) begin
          // Timeout pulse only when neither higher-priority release applies.
          timeout_s  = !done && req[gidx_r] && tmo_hit_s;
          grant_s    = '0;
          ptr_s      = gidx_r + IDX_W'(1);
          hold_cnt_s = '0;
          state_s    = ST_IDLE;
        end else if (hold_cnt_r != CNT_W'(MAX_HOLD)) begin
          hold_cnt_s = hold_cnt_r + CNT_W'(1);
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      default: begin
        grant_s    = '0;
        hold_cnt_s = '0;
        state_s    = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      ptr_r         <= '0;
      gidx_r        <= '0;
      hold_cnt_r    <= '0;
      grant_r       <= '0;
      grant_valid_r <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      ptr_r         <= ptr_s;
      gidx_r        <= gidx_s;
      hold_cnt_r    <= hold_cnt_s;
      grant_r       <= grant_s;
      grant_valid_r <= |grant_s;
      timeout_r     <= timeout_s;
    end
  end

  assign grant       = grant_r;
  assign grant_valid = grant_valid_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Self-checking bench for rr_request_arbiter: a cycle-level behavioural model
// of the arbitration rules is compared against the DUT every cycle, and
// directed scenarios carry hand-computed literal expectations.
module tb_rr_request_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic         timeout;

  int errors = 0;
  int checks = 0;

  rr_request_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // owner: index currently holding the grant, -1 when nobody does
  // held:  number of cycles the current grant has already been visible
  int owner = -1;
  int next_first = 0;
  int held = 0;
  bit m_timeout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1; next_first = 0; held = 0; m_timeout = 1'b0;
    end else if (owner < 0) begin
      m_timeout = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && req[(next_first + k) % N]) owner = (next_first + k) % N;
      end
      held = 1;
    end else begin
      // the grant has now been visible for 'held' full cycles
      if (done || !req[owner] || (MAX_HOLD != 0 && held >= MAX_HOLD)) begin
        m_timeout  = !done && req[owner];
        next_first = (owner + 1) % N;
        owner      = -1;
      end else begin
        m_timeout = 1'b0;
        held++;
      end
    end
  end

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (owner >= 0) g[owner] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic prev_timeout = 1'b0;

  // Compare process: DUT against model on every falling edge, plus invariants.
  always @(negedge clk) begin
    chk("model_grant", 32'(grant), 32'(model_grant()));
    chk("model_grant_valid", 32'(grant_valid), 32'(owner >= 0));
    chk("model_timeout", 32'(timeout), 32'(m_timeout));
    chk("onehot_or_zero", 32'($countones(grant) <= 1), 32'd1);
    chk("timeout_not_back_to_back", 32'(prev_timeout && timeout), 32'd0);
    prev_timeout = timeout;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #7;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_grant_valid", 32'(grant_valid), 32'h0);
    chk("reset_timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;
    tick();

    // Scenario 1: req=0110 from ptr 0
    req = 4'b0110;
    tick();
    chk("s1_first_grant", 32'(grant), 32'h2);
    chk("s1_valid", 32'(grant_valid), 32'h1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("s1_gap", 32'(grant), 32'h0);
    tick();
    chk("s1_second_grant", 32'(grant), 32'h4);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b1111;
    chk("s1_release", 32'(grant), 32'h0);
    tick();
    chk("s1_ptr_is_3", 32'(grant), 32'h8);
    do_reset();
    tick();

    // Scenario 2: full rotation with wrap
    begin
      logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("s2_rotation", 32'(grant), 32'(seq[i]));
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("s2_gap", 32'(grant), 32'h0);
      end
    end
    do_reset();
    req = 4'b0000;
    tick();

    // Scenario 3: hold timeout after exactly MAX_HOLD cycles
    req = 4'b0001;
    tick();
    chk("s3_grant_start", 32'(grant), 32'h1);
    for (int i = 1; i < MAX_HOLD; i++) begin
      tick();
      chk("s3_grant_held", 32'(grant), 32'h1);
      chk("s3_no_timeout_yet", 32'(timeout), 32'h0);
    end
    tick();
    chk("s3_revoked", 32'(grant), 32'h0);
    chk("s3_timeout_pulse", 32'(timeout), 32'h1);
    tick();
    chk("s3_regrant", 32'(grant), 32'h1);
    chk("s3_timeout_gone", 32'(timeout), 32'h0);

    // Scenario 4: done coincides with the timeout edge
    for (int i = 1; i < MAX_HOLD; i++) tick();
    chk("s4_still_held", 32'(grant), 32'h1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("s4_released", 32'(grant), 32'h0);
    chk("s4_no_timeout", 32'(timeout), 32'h0);
    req = 4'b0000;
    do_reset();
    tick();

    // Scenario 5: request drop releases, no preemption
    req = 4'b0100;
    tick();
    chk("s5_grant2", 32'(grant), 32'h4);
    req = 4'b1100;
    tick();
    chk("s5_no_preempt", 32'(grant), 32'h4);
    req = 4'b0001;
    tick();
    chk("s5_drop_release", 32'(grant), 32'h0);
    tick();
    chk("s5_grant0", 32'(grant), 32'h1);
    req = 4'b0000;
    do_reset();
    tick();

    // Scenario 6: async reset mid-grant
    req = 4'b1000;
    tick();
    chk("s6_grant3", 32'(grant), 32'h8);
    rst_n = 1'b0;
    req   = 4'b1001;
    #1;
    chk("s6_async_grant", 32'(grant), 32'h0);
    chk("s6_async_valid", 32'(grant_valid), 32'h0);
    chk("s6_async_timeout", 32'(timeout), 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("s6_ptr_reset", 32'(grant), 32'h1);
    req = 4'b0000;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
